// File: rtl/sigma_delta_tx.sv
// First-order sigma-delta bitstream transmitter with a small sample FIFO.
// Ports: clk, rst_n, s_valid/s_ready/s_data in, enable, bit_out, sample_tick, underrun, fifo_level.
module sigma_delta_tx #(
  parameter int SAMPLE_BITS = 10,
  parameter int OSR_LOG2    = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter bit INVERT      = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [SAMPLE_BITS-1:0]          s_data,
  input  logic                            enable,
  output logic                            bit_out,
  output logic                            sample_tick,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [OSR_LOG2-1:0] PHASE_MAX = '1;
  localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

  logic [SAMPLE_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          count;

  logic [0:0]             state;
  logic [SAMPLE_BITS-1:0] acc;
  logic [SAMPLE_BITS-1:0] level;
  logic [OSR_LOG2-1:0]    phase;

  logic                   push;
  logic                   pop;
  logic                   not_empty;
  logic                   boundary;
  logic [SAMPLE_BITS:0]   sum;
  logic [SAMPLE_BITS-1:0] head;

  assign s_ready    = count < DEPTH;
  assign fifo_level = count;
  assign not_empty  = count != '0;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];
  assign boundary   = (state == RUN) && (phase == PHASE_MAX);
  // Loads happen only while enabled; a boundary with enable low
  // goes back to IDLE without consuming a sample.
  assign pop        = enable && not_empty
                   && ((state == IDLE) || boundary);
  assign sample_tick = pop;
  assign sum        = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      level    <= '0;
      phase    <= '0;
      bit_out  <= INVERT;
      underrun <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          acc      <= '0;
          phase    <= '0;
          bit_out  <= INVERT;
          underrun <= 1'b0;
          if (pop) begin
            level <= head;
            state <= RUN;
          end
        end
        (state == RUN && !enable): begin
          state    <= IDLE;
          acc      <= '0;
          phase    <= '0;
          bit_out  <= INVERT;
          underrun <= 1'b0;
        end
        default: begin
          // Carry out of the N-bit accumulator is the density bit.
          acc     <= sum[SAMPLE_BITS-1:0];
          bit_out <= sum[SAMPLE_BITS] ^ INVERT;
          phase   <= phase + OSR_LOG2'(1);
          if (boundary) begin
            if (not_empty) level <= head;
            else           underrun <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_delta_tx.sv
// Self-checking bench for sigma_delta_tx: density vectors plus
// hand sequences for FIFO, underrun, async reset and boundary push.
module tb_sigma_delta_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] s_data;
  logic       enable;
  logic       bit_out;
  logic       sample_tick;
  logic       underrun;
  logic [2:0] fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sigma_delta_tx #(
    .SAMPLE_BITS(10),
    .OSR_LOG2(10),
    .FIFO_DEPTH(4),
    .INVERT(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .enable(enable),
    .bit_out(bit_out),
    .sample_tick(sample_tick),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  typedef struct {
    logic [9:0] sample;
    int         exp_ones;
    logic       exp_underrun;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = '0;
    enable  = 1'b0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [9:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step();
    s_valid = 1'b0;
  endtask

  // Enable from IDLE with a sample buffered; returns after the
  // edge that registers the first modulated bit.
  task automatic start_run(input string name);
    enable = 1'b1;
    #1;
    chk({name, "_tick_start"}, sample_tick, 1);
    step();
    step();
  endtask

  initial begin
    int ones;
    int zeros;
    int gap;
    int wait_n;
    logic b0;
    logic b1;

    vecs[0] = '{10'd850,  850,  1'b1};
    vecs[1] = '{10'd0,    0,    1'b1};
    vecs[2] = '{10'd1023, 1023, 1'b1};
    vecs[3] = '{10'd512,  512,  1'b1};
    vecs[4] = '{10'd1,    1,    1'b1};
    vecs[5] = '{10'd341,  341,  1'b1};

    do_reset();
    chk("rst_bit_out", bit_out, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", s_ready, 1);

    // Enable with an empty FIFO: stays idle, no underrun.
    enable = 1'b1;
    #1;
    chk("idle_empty_tick", sample_tick, 0);
    step();
    step();
    chk("idle_empty_underrun", underrun, 0);
    chk("idle_empty_bit", bit_out, 0);
    enable = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      push(vecs[v].sample);
      start_run("vec");
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
        ones += int'(bit_out);
        step();
      end
      chk($sformatf("vec%0d_ones", v), ones, vecs[v].exp_ones);
      chk($sformatf("vec%0d_underrun", v), underrun,
          int'(vecs[v].exp_underrun));
    end

    // Two samples: zero window then full-scale window.
    do_reset();
    push(10'd0);
    push(10'd1023);
    enable = 1'b1;
    #1;
    chk("t2_tick_start", sample_tick, 1);
    ones  = 0;
    zeros = 0;
    gap   = -1;
    for (int j = 1; j <= 2049; j++) begin
      step();
      if (sample_tick && gap < 0) gap = j;
      if (j >= 2 && j <= 1025) zeros += int'(bit_out);
      if (j >= 1026) ones += int'(bit_out);
    end
    chk("t2_first_window", zeros, 0);
    chk("t2_second_window", ones, 1023);
    chk("t2_tick_gap", gap, 1024);

    // Backpressure while idle: 5 offered, 4 accepted.
    do_reset();
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 10'(100 * (k + 1));
      #1;
      chk($sformatf("t3_ready%0d", k), s_ready, (k < 4) ? 1 : 0);
      step();
    end
    chk("t3_level", fifo_level, 4);
    chk("t3_ready_full", s_ready, 0);
    s_valid = 1'b0;

    // Full FIFO at a boundary with s_valid held high.
    enable = 1'b1;
    step();
    chk("t6_after_start", fifo_level, 3);
    push(10'd777);
    chk("t6_refill", fifo_level, 4);
    s_valid = 1'b1;
    s_data  = 10'd888;
    wait_n  = 0;
    while (!sample_tick && wait_n < 1100) begin
      step();
      wait_n++;
    end
    chk("t6_tick_found", sample_tick, 1);
    chk("t6_level_a", fifo_level, 4);
    chk("t6_ready_a", s_ready, 0);
    step();
    chk("t6_level_b", fifo_level, 3);
    step();
    chk("t6_level_c", fifo_level, 4);
    s_valid = 1'b0;

    // Single sample: underrun at first boundary, level repeats.
    do_reset();
    push(10'd512);
    enable = 1'b1;
    #1;
    chk("t4_tick_start", sample_tick, 1);
    ones = 0;
    for (int j = 1; j <= 2049; j++) begin
      step();
      if (j == 1024) chk("t4_underrun_pre", underrun, 0);
      if (j == 1025) chk("t4_underrun_post", underrun, 1);
      if (j >= 1026) ones += int'(bit_out);
    end
    chk("t4_second_window", ones, 512);
    enable = 1'b0;
    step();
    chk("t4_underrun_clear", underrun, 0);
    chk("t4_bit_idle", bit_out, 0);

    // Async reset mid-run, then restart from acc = 0.
    do_reset();
    push(10'd700);
    push(10'd100);
    enable = 1'b1;
    for (int j = 0; j < 302; j++) step();
    rst_n   = 1'b0;
    enable  = 1'b0;
    #1;
    chk("t5_bit_out", bit_out, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ready", s_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    push(10'd850);
    start_run("t5");
    b0 = bit_out;
    step();
    b1 = bit_out;
    chk("t5_first_bit", b0, 0);
    chk("t5_second_bit", b1, 1);
    ones = int'(b0) + int'(b1);
    for (int i = 2; i < 1024; i++) begin
      ones += int'(bit_out);
      step();
    end
    chk("t5_ones", ones, 850);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
